// File: rtl/imem_boot_pkg.sv
// Shared types and defaults for the instruction-memory boot sequencer.
package imem_boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        RUN,
        HALT,
        DONE
    } boot_state_t;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_ADDR_W   = 11;
    localparam int DEF_DEPTH    = 2048;
    localparam int DEF_RST_HOLD = 4;

endpackage

// File: rtl/boot_cycle_counter.sv
// Saturating up-counter with synchronous clear and a compare-to-limit flag.
module boot_cycle_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_lim,
    output logic [W-1:0] o_cnt,
    output logic         o_hit
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_hit = (r_cnt == i_lim);

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot sequencer: streams a program into the instruction SRAM, then
// releases the core and gates its run enable.
module imem_boot_ctrl
    import imem_boot_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int RST_HOLD = DEF_RST_HOLD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              load_valid,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic [31:0]       run_limit,
    input  logic              halt_req,
    input  logic              resume,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_a,
    output logic [WIDTH-1:0]  mem_d,
    output logic              mem_wen_n,
    output logic              core_rst,
    output logic              core_enable,
    output logic [31:0]       cycle_cnt,
    output logic [ADDR_W:0]   words_loaded,
    output logic              err_full,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
    localparam logic [3:0]        HOLD_M1 = 4'(RST_HOLD - 1);

    boot_state_t r_state;
    boot_state_t w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_limit;
    logic              w_go;
    logic              w_acc;
    logic              w_final;
    logic              w_run_hit;
    logic              w_hold_hit;
    logic [3:0]        w_unused_hold_cnt;

    assign load_ready = (r_state == LOAD);
    assign w_acc      = load_valid && load_ready;
    assign w_final    = w_acc && (load_last || (r_addr == LAST_A));
    assign w_go       = start && (r_state inside {IDLE, HALT, DONE});

    boot_cycle_counter #(.W(32)) u_run_cnt (
        .clk   (clk),
        .rst_n (rst),
        .i_clr (w_go),
        .i_en  (r_state == RUN),
        .i_lim (r_limit - 32'd1),
        .o_cnt (cycle_cnt),
        .o_hit (w_run_hit)
    );

    // Hold counter restarts on every FLUSH entry; first FLUSH cycle is 0.
    boot_cycle_counter #(.W(4)) u_hold_cnt (
        .clk   (clk),
        .rst_n (rst),
        .i_clr (r_state != FLUSH),
        .i_en  (r_state == FLUSH),
        .i_lim (HOLD_M1),
        .o_cnt (w_unused_hold_cnt),
        .o_hit (w_hold_hit)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (start) w_next = LOAD;
            LOAD:  if (w_final) w_next = FLUSH;
            FLUSH: if (w_hold_hit) w_next = RUN;
            RUN: begin
                if ((r_limit != 32'd0) && w_run_hit) w_next = DONE;
                else if (halt_req) w_next = HALT;
            end
            HALT: begin
                if (start) w_next = LOAD;
                else if (resume && !halt_req) w_next = RUN;
            end
            DONE:  if (start) w_next = LOAD;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_limit      <= '0;
            mem_sel      <= 1'b1;
            mem_a        <= '0;
            mem_d        <= '0;
            mem_wen_n    <= 1'b1;
            core_rst     <= 1'b0;
            core_enable  <= 1'b0;
            words_loaded <= '0;
            err_full     <= 1'b0;
            done         <= 1'b0;
        end else begin
            r_state     <= w_next;
            mem_sel     <= !(w_next inside {RUN, HALT, DONE});
            core_rst    <= (w_next inside {RUN, HALT, DONE});
            core_enable <= (w_next == RUN);
            done        <= (r_state == RUN) && (w_next == DONE);
            mem_wen_n   <= !w_acc;
            if (w_go) begin
                r_addr       <= '0;
                words_loaded <= '0;
                err_full     <= 1'b0;
                r_limit      <= run_limit;
            end
            if (w_acc) begin
                mem_a        <= r_addr;
                mem_d        <= load_data;
                words_loaded <= {1'b0, r_addr} + (ADDR_W + 1)'(1);
                if (!w_final) r_addr <= r_addr + ADDR_W'(1);
                if (!load_last && (r_addr == LAST_A)) err_full <= 1'b1;
            end
        end
    end

endmodule
